passcode_ctrl: RTL

Sequencing controller around three-digit passcode checking for the keypad lock path. Accepts one 4-bit digit per `din_valid` strobe, compares the full three-digit entry against the programmed code, and drives a timed `unlock` pulse on success. Counts consecutive failures and enforces a timed lockout after `MAX_TRIES` bad entries. Also handles cancel and inter-digit timeout. Sits between the keypad/debounce front end and the actuator/display logic.

---
 rtl/passcode_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/passcode_ctrl.sv
// Three-digit keypad passcode sequencer: gathers three digits, then either pulses unlock or
// counts a failure, entering a timed lockout after MAX_TRIES consecutive failures.
module passcode_ctrl #(
    parameter logic [3:0]  CODE0          = 4'hC,
    parameter logic [3:0]  CODE1          = 4'hC,
    parameter logic [3:0]  CODE2          = 4'hD,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCK_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       cancel,
    output logic       unlock,
    output logic       locked,
    output logic       err,
    output logic [2:0] fails,
    output logic [2:0] prs_state
);

    localparam int unsigned MAX_OL =
        (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned MAX_DWELL =
        (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = (MAX_DWELL > 2) ? $clog2(MAX_DWELL) : 1;

    // The dwell counter is loaded with N-1 so that the exit edge is the N-th one after entry.
    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       MAX_T     = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGot1 = 3'd1,
        StGot2 = 3'd2,
        StOpen = 3'd3,
        StFail = 3'd4,
        StLock = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       fails_q, fails_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0]       fails_inc;
    logic             final_bad;

    assign fails_inc = {1'b0, fails_q} + 4'd1;
    assign final_bad = mismatch_q | (din != CODE2);

    always_comb begin
        state_d    = state_q;
        fails_d    = fails_q;
        mismatch_d = mismatch_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (din_valid) begin
                    state_d    = StGot1;
                    mismatch_d = (din != CODE0);
                    cnt_d      = TO_LOAD;
                end
            end

            StGot1: begin
                if (cancel) begin
                    state_d    = StIdle;
                    mismatch_d = 1'b0;
                end else if (din_valid) begin
                    state_d    = StGot2;
                    mismatch_d = mismatch_q | (din != CODE1);
                    cnt_d      = TO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d    = StIdle;
                    mismatch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            StGot2: begin
                if (cancel) begin
                    state_d    = StIdle;
                    mismatch_d = 1'b0;
                end else if (din_valid) begin
                    mismatch_d = 1'b0;
                    if (!final_bad) begin
                        state_d = StOpen;
                        fails_d = 3'd0;
                        cnt_d   = OPEN_LOAD;
                    end else if (fails_inc >= MAX_T) begin
                        // Saturate: fails never exceeds MAX_TRIES.
                        state_d = StLock;
                        fails_d = MAX_T[2:0];
                        err_d   = 1'b1;
                        cnt_d   = LOCK_LOAD;
                    end else begin
                        state_d = StFail;
                        fails_d = fails_inc[2:0];
                        err_d   = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d    = StIdle;
                    mismatch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            StOpen: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            StFail: begin
                state_d = StIdle;
            end

            StLock: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    fails_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d    = StIdle;
                mismatch_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            fails_q    <= 3'd0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fails_q    <= fails_d;
            mismatch_q <= mismatch_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign unlock    = (state_q == StOpen);
    assign locked    = (state_q == StLock);
    assign err       = err_q;
    assign fails     = fails_q;
    assign prs_state = state_q;

endmodule
